// File: rtl/rot_seq_pkg.sv
// Shared types for the rotate command sequencer: command record, FSM states, rotate direction.
package rot_seq_pkg;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } rot_dir_t;

  typedef struct packed {
    logic [3:0] data;
    logic [1:0] amt;
    rot_dir_t   dir;
    logic [1:0] rpt;
  } rot_cmd_t;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } seq_state_t;

endpackage

// File: rtl/rot_cmd_sequencer_if.sv
// Command, rotate-unit and result-stream signals of the rotate command sequencer.
interface rot_cmd_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_data;
  logic [1:0] cmd_amt;
  logic       cmd_dir;
  logic [1:0] cmd_rpt;

  logic [3:0] bs_data;
  logic [1:0] bs_amt;
  logic       bs_dir;
  logic [3:0] bs_result;

  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic       out_last;

  // environment side: command source, rotate unit and result sink
  modport master (
    output cmd_valid, cmd_data, cmd_amt, cmd_dir, cmd_rpt,
    input  cmd_ready,
    input  bs_data, bs_amt, bs_dir,
    output bs_result,
    input  out_valid, out_data, out_last,
    output out_ready
  );

  modport slave (
    input  cmd_valid, cmd_data, cmd_amt, cmd_dir, cmd_rpt,
    output cmd_ready,
    output bs_data, bs_amt, bs_dir,
    input  bs_result,
    output out_valid, out_data, out_last,
    input  out_ready
  );
endinterface

// File: rtl/rot_cmd_fifo.sv
// Synchronous command FIFO with full/empty flags; DEPTH must be a power of two >= 2.
module rot_cmd_fifo
  import rot_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push,
  input  rot_cmd_t wr_cmd,
  input  logic     pop,
  output rot_cmd_t rd_cmd,
  output logic     full,
  output logic     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = PTR_W + 1;

  rot_cmd_t         mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_cmd  = mem[rd_ptr];

  // storage needs no reset; occupancy alone decides what is valid
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_cmd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rot_cmd_sequencer.sv
// Buffers rotate commands and replays each through the external rotate unit rpt+1 times.
// Optional completed-command counter port enabled by macro ROT_SEQ_CMD_CNT_EN.
//
// state | meaning
// IDLE  | waiting for a command; pops the FIFO head into the current-command registers
// ISSUE | drives the rotate unit and captures one result per fire until remaining hits 0
module rot_cmd_sequencer
  import rot_seq_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
`ifdef ROT_SEQ_CMD_CNT_EN
  ,
  parameter int CNT_W      = 16
`endif
) (
  input  logic                   clk,
  input  logic                   rst_n,
  rot_cmd_sequencer_if.slave     bus
`ifdef ROT_SEQ_CMD_CNT_EN
  ,
  output logic [CNT_W-1:0]       cmd_done_cnt
`endif
);

  seq_state_t state;
  rot_cmd_t   wr_cmd;
  rot_cmd_t   head;
  logic       full;
  logic       empty;
  logic       push;
  logic       pop;
  logic       fire;
  logic [3:0] cur_data;
  logic [1:0] cur_amt;
  rot_dir_t   cur_dir;
  logic [1:0] remaining;

  assign wr_cmd = '{data: bus.cmd_data, amt: bus.cmd_amt,
                    dir: rot_dir_t'(bus.cmd_dir), rpt: bus.cmd_rpt};

  assign bus.cmd_ready = !full;
  assign push          = bus.cmd_valid && !full;
  assign pop           = (state == IDLE) && !empty;
  assign fire          = !bus.out_valid || bus.out_ready;

  assign bus.bs_data = cur_data;
  assign bus.bs_amt  = cur_amt;
  assign bus.bs_dir  = cur_dir;

  rot_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push   (push),
    .wr_cmd (wr_cmd),
    .pop    (pop),
    .rd_cmd (head),
    .full   (full),
    .empty  (empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cur_data      <= '0;
      cur_amt       <= '0;
      cur_dir       <= DIR_LEFT;
      remaining     <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_last  <= 1'b0;
    end else begin
      // a fire below overrides this drop, giving back-to-back beats
      if (bus.out_ready) bus.out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (!empty) begin
            cur_data  <= head.data;
            cur_amt   <= head.amt;
            cur_dir   <= head.dir;
            remaining <= head.rpt;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (fire) begin
            bus.out_data  <= bus.bs_result;
            bus.out_valid <= 1'b1;
            bus.out_last  <= (remaining == 2'd0);
            cur_data      <= bus.bs_result;
            if (remaining == 2'd0) state <= IDLE;
            else                   remaining <= remaining - 2'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ROT_SEQ_CMD_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cmd_done_cnt <= '0;
    else if (bus.out_valid && bus.out_ready && bus.out_last)
      cmd_done_cnt <= cmd_done_cnt + CNT_W'(1);
  end
`endif

endmodule
